// File: rtl/axi_reg_master_pkg.sv
// Shared AXI3 encodings and FSM state type for the register-command AXI master.
package axi_reg_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_SIZE_4B    = 2'b10;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RSP
    } state_e;

endpackage

// File: rtl/axi_reg_master.sv
// Single-outstanding AXI3 master: converts one register command into a one-beat
// AXI write or read and returns the slave's response on a valid/ready channel.
module axi_reg_master
    import axi_reg_master_pkg::*;
#(
    parameter int unsigned          ID_WIDTH = 12,
    parameter logic [ID_WIDTH-1:0]  ID_INIT  = '0
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [31:0]         cmd_addr,
    input  logic [31:0]         cmd_wdata,
    input  logic [3:0]          cmd_wstb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_proto_err,
    output logic                busy,
    output logic [31:0]         AWADDR,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ID_WIDTH-1:0] AWID,
    output logic [3:0]          AWLEN,
    output logic [1:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic [31:0]         WDATA,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [ID_WIDTH-1:0] WID,
    output logic                WLAST,
    output logic [3:0]          WSTRB,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [ID_WIDTH-1:0] BID,
    input  logic [1:0]          BRESP,
    output logic [31:0]         ARADDR,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ID_WIDTH-1:0] ARID,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    input  logic [31:0]         RDATA,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [ID_WIDTH-1:0] RID,
    input  logic                RLAST,
    input  logic [1:0]          RRESP
);

    state_e              r_state, w_next;
    logic                r_live;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstb;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_aw_done;
    logic                r_w_done;
    logic [31:0]         r_rdata;
    axi_resp_e           r_resp;
    logic                r_perr;

    logic w_accept;
    logic w_aw_fin;
    logic w_w_fin;
    logic w_b_hs;
    logic w_r_hs;
    logic w_rsp_hs;

    // r_live holds cmd_ready low until the first clock edge after reset release.
    assign cmd_ready = r_live && (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_aw_fin  = r_aw_done || AWREADY;
    assign w_w_fin   = r_w_done || WREADY;
    assign w_b_hs    = (r_state == ST_WR_B) && BVALID;
    assign w_r_hs    = (r_state == ST_RD_R) && RVALID;
    assign w_rsp_hs  = (r_state == ST_RSP) && rsp_ready;

    assign AWADDR  = r_addr;
    assign AWVALID = (r_state == ST_WR) && !r_aw_done;
    assign AWID    = r_id;
    assign AWLEN   = AXI_LEN_SINGLE;
    assign AWSIZE  = AXI_SIZE_4B;
    assign AWBURST = AXI_BURST_INCR;
    assign WDATA   = r_wdata;
    assign WVALID  = (r_state == ST_WR) && !r_w_done;
    assign WID     = r_id;
    assign WLAST   = WVALID;
    assign WSTRB   = r_wstb;
    assign BREADY  = (r_state == ST_WR_B);
    assign ARADDR  = r_addr;
    assign ARVALID = (r_state == ST_RD_AR);
    assign ARID    = r_id;
    assign ARLEN   = AXI_LEN_SINGLE;
    assign ARSIZE  = AXI_SIZE_4B;
    assign ARBURST = AXI_BURST_INCR;
    assign RREADY  = (r_state == ST_RD_R);

    assign rsp_valid     = (r_state == ST_RSP);
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_proto_err = r_perr;
    assign busy          = (r_state != ST_IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = cmd_we ? ST_WR : ST_RD_AR;
            ST_WR:    if (w_aw_fin && w_w_fin) w_next = ST_WR_B;
            ST_WR_B:  if (BVALID) w_next = ST_RSP;
            ST_RD_AR: if (ARREADY) w_next = ST_RD_R;
            ST_RD_R:  if (RVALID) w_next = ST_RSP;
            ST_RSP:   if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstb    <= '0;
            r_id      <= ID_INIT;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
            r_perr    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr & 32'hFFFF_FFFC;
                r_wdata   <= cmd_wdata;
                r_wstb    <= cmd_wstb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            // AW and W retire independently; each valid drops after its own handshake.
            if (r_state == ST_WR) begin
                if (AWREADY) r_aw_done <= 1'b1;
                if (WREADY)  r_w_done  <= 1'b1;
            end
            if (w_b_hs) begin
                r_rdata <= '0;
                r_resp  <= axi_resp_e'(BRESP);
                r_perr  <= (BID != r_id);
            end
            if (w_r_hs) begin
                r_rdata <= RDATA;
                r_resp  <= axi_resp_e'(RRESP);
                r_perr  <= (RID != r_id) || !RLAST;
            end
            if (w_rsp_hs) r_id <= r_id + 1'b1;
        end
    end

endmodule
